// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU: stalls the pipeline while iterating, then
// pulses div_ready with {remainder,quotient}. Optional fast divide-by-zero path: DIV_ZERO_FAST_EN.
//
// state | meaning
// IDLE  | waiting for div_start; latches magnitudes and signs on start
// ZERO  | divisor was zero: one-cycle shortcut result (DIV_ZERO_FAST_EN only)
// ON    | one quotient bit per cycle, DATA_W iterations
// DONE  | div_ready pulse, fixed-up result visible on div_result
module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic [DATA_W-1:0]     div_opdata1,
    input  logic [DATA_W-1:0]     div_opdata2,
    input  logic                  flush,
    output logic                  stallreq_div,
    output logic                  div_ready,
    output logic [2*DATA_W-1:0]   div_result
);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ZERO = 2'd1, ON = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd2, DONE = 2'd3} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   dvs;
    logic                sign1, sign2;
    logic [2*DATA_W-1:0] result;

    logic                load, iterate, finish;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   quo_step, rem_step;
    logic [DATA_W-1:0]   q_raw, r_raw, q_fix, r_fix;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic                op1_neg, op2_neg;

    assign op1_neg = div_signed & div_opdata1[DATA_W-1];
    assign op2_neg = div_signed & div_opdata2[DATA_W-1];
    assign op1_abs = op1_neg ? -div_opdata1 : div_opdata1;
    assign op2_abs = op2_neg ? -div_opdata2 : div_opdata2;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        iterate      = 1'b0;
        finish       = 1'b0;
        stallreq_div = 1'b0;
        div_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (div_start && !flush) begin
                    stallreq_div = 1'b1;
                    load         = 1'b1;
                    state_nxt    = ON;
`ifdef DIV_ZERO_FAST_EN
                    if (div_opdata2 == '0) begin
                        state_nxt = ZERO;
                    end
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                stallreq_div = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
`endif
            ON: begin
                stallreq_div = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt == LAST_CNT) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // start is still high here for the same instruction; never restart from DONE
                div_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: the dividend shifts out of quo's MSB as quotient bits shift in.
    always_comb begin
        trial = {rem, quo[DATA_W-1]} - {1'b0, dvs};
        if (!trial[DATA_W]) begin
            rem_step = trial[DATA_W-1:0];
            quo_step = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_step = {rem[DATA_W-2:0], quo[DATA_W-1]};
            quo_step = {quo[DATA_W-2:0], 1'b0};
        end
    end

    // Outside ON the only finishing state is ZERO, where quo still holds |dividend|.
    always_comb begin
        q_raw = (state == ON) ? quo_step : '1;
        r_raw = (state == ON) ? rem_step : quo;
        q_fix = (sign1 ^ sign2) ? -q_raw : q_raw;
        r_fix = sign1 ? -r_raw : r_raw;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            result <= '0;
        end else begin
            if (load) begin
                quo   <= op1_abs;
                dvs   <= op2_abs;
                rem   <= '0;
                cnt   <= '0;
                sign1 <= op1_neg;
                sign2 <= op2_neg;
            end else if (iterate) begin
                quo <= quo_step;
                rem <= rem_step;
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                result <= {r_fix, q_fix};
            end
        end
    end

    assign div_result = result;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, randomized divides against
// an arithmetic reference model, and hand sequences for flush, reset and no-restart cases.
module tb_div_seq_ctrl;

    logic        clk;
    logic        cpu_rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        flush;
    logic        stallreq_div;
    logic        div_ready;
    logic [63:0] div_result;

    int errors = 0;
    int checks = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (cpu_rst),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_opdata1  (div_opdata1),
        .div_opdata2  (div_opdata2),
        .flush        (flush),
        .stallreq_div (stallreq_div),
        .div_ready    (div_ready),
        .div_result   (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint aa, bb, q, r;
        logic   sa, sb;
        sa = sgn && a[31];
        sb = sgn && b[31];
        aa = longint'({32'd0, a});
        bb = longint'({32'd0, b});
        if (sa) aa = 64'sh1_0000_0000 - aa;
        if (sb) bb = 64'sh1_0000_0000 - bb;
        if (bb == 0) begin
            q = 64'sh0_FFFF_FFFF;
            r = aa;
        end else begin
            q = aa / bb;
            r = aa % bb;
        end
        if (sa ^ sb) q = -q;
        if (sa) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (b == 32'd0) ? ZERO_LAT : 33;
    endfunction

    // Start at a negedge, hold start through DONE, then drop it and confirm no restart.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [63:0] res, output int lat);
        bit stall_ok;
        @(negedge clk);
        div_opdata1 = a;
        div_opdata2 = b;
        div_signed  = sgn;
        div_start   = 1'b1;
        lat = -1;
        res = '0;
        stall_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (div_ready) begin
                lat = k;
                res = div_result;
                chk("stall_in_done", {63'd0, stallreq_div}, 64'd0);
                break;
            end
            if (!stallreq_div) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk("stall_while_busy", {63'd0, stall_ok}, 64'd1);
        @(negedge clk);
        div_start = 1'b0;
        #1;
        chk("no_restart_after_done", {62'd0, stallreq_div, div_ready}, 64'd0);
    endtask

    task automatic watch_idle(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            if (div_ready || stallreq_div) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    vec_t        vecs[7];
    logic [63:0] res, last_res, exp_res;
    int          lat;
    logic [31:0] ra, rb;
    logic        rs;

    initial begin
        vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2,        32'd14}};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1,        32'hFFFF_FFFD}};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0,        32'h8000_0000}};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0}};
        vecs[5] = '{32'd5,          32'd0,          1'b0, {32'd5,        32'hFFFF_FFFF}};
        vecs[6] = '{32'hFFFF_FFFB,  32'd0,          1'b1, {32'hFFFF_FFFB, 32'd1}};

        cpu_rst     = 1'b1;
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd50;
        div_opdata2 = 32'd3;
        flush       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {stallreq_div, div_ready, div_result[61:0]}, 64'd0);
        div_start = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        cpu_rst = 1'b0;
        #1;
        chk("after_reset_outputs", {stallreq_div, div_ready, div_result[61:0]}, 64'd0);

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
            last_res = res;
        end

        for (int n = 0; n < 24; n++) begin
            ra = (($urandom_range(0, 5)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            exp_res = ref_div(ra, rb, rs);
            run_div(ra, rb, rs, res, lat);
            chk($sformatf("rand%0d_%h_%h_%0d_result", n, ra, rb, rs), res, exp_res);
            chk($sformatf("rand%0d_latency", n), 64'(lat), 64'(exp_lat(rb)));
            last_res = res;
        end

        // Flush at iteration 10: start cycle is 0, ON iteration k runs in cycle k+1.
        @(negedge clk);
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd3;
        div_signed  = 1'b0;
        div_start   = 1'b1;
        repeat (11) @(negedge clk);
        flush     = 1'b1;
        div_start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall_ready_low", {62'd0, stallreq_div, div_ready}, 64'd0);
        chk("flush_result_kept", div_result, last_res);
        watch_idle("flush_no_ready", 40);
        run_div(32'd9, 32'd3, 1'b0, res, lat);
        chk("post_flush_result", res, {32'd0, 32'd3});
        chk("post_flush_latency", 64'(lat), 64'd33);
        last_res = res;

        // Flush wins over start in IDLE.
        @(negedge clk);
        div_opdata1 = 32'd77;
        div_opdata2 = 32'd5;
        div_start   = 1'b1;
        flush       = 1'b1;
        #1;
        chk("flush_prio_stall", {63'd0, stallreq_div}, 64'd0);
        @(negedge clk);
        div_start = 1'b0;
        flush     = 1'b0;
        watch_idle("flush_prio_no_start", 40);
        chk("flush_prio_result_kept", div_result, last_res);

        // Reset in the middle of ON.
        @(negedge clk);
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        div_start   = 1'b1;
        repeat (6) @(negedge clk);
        cpu_rst   = 1'b1;
        div_start = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_on_reset_outputs", {stallreq_div, div_ready, div_result[61:0]}, 64'd0);
        chk("mid_on_reset_result", div_result, 64'd0);
        cpu_rst = 1'b0;
        watch_idle("mid_on_reset_no_ready", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
